// File: rtl/fsqrt_arb.sv
// Arbiter/sequencer sharing one pipelined, handshake-free fsqrt unit among NREQ requesters.
// Define FSQRT_ARB_RR_EN for round-robin arbitration; otherwise lowest eligible index wins.
module fsqrt_arb #(
    parameter int NREQ     = 4,
    parameter int SQRT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_y,
    output logic [31:0]          sqrt_x,
    input  logic [31:0]          sqrt_y
);

    logic [NREQ-1:0] busy;
    logic [7:0]      elig;
    logic            grant_any;
    logic [2:0]      winner;
    logic            tag_v   [SQRT_LAT];
    logic [2:0]      tag_idx [SQRT_LAT];

`ifdef FSQRT_ARB_RR_EN
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] rr_ptr;
`endif

    // Padded to 8 bits so the 3-bit winner index selects it without width games.
    always_comb begin
        elig = '0;
        elig[NREQ-1:0] = req_valid & ~busy;
    end

    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        if (!rst) begin
`ifdef FSQRT_ARB_RR_EN
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant_any && elig[3'((32'(rr_ptr) + i) % NREQ)]) begin
                    grant_any = 1'b1;
                    winner    = 3'((32'(rr_ptr) + i) % NREQ);
                end
            end
`else
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant_any && elig[3'(i)]) begin
                    grant_any = 1'b1;
                    winner    = 3'(i);
                end
            end
`endif
        end
    end

    always_comb begin
        req_ready = '0;
        sqrt_x    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_any && winner == 3'(i)) begin
                req_ready[i] = 1'b1;
                sqrt_x       = req_x[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            for (int unsigned i = 0; i < SQRT_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
`ifdef FSQRT_ARB_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            tag_v[0]   <= grant_any;
            tag_idx[0] <= winner;
            for (int unsigned i = 1; i < SQRT_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
            // busy guarantees a writeback never meets a still-full buffer.
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (req_ready[k])
                    busy[k] <= 1'b1;
                else if (rsp_valid[k] && rsp_ready[k])
                    busy[k] <= 1'b0;

                if (tag_v[SQRT_LAT-1] && tag_idx[SQRT_LAT-1] == 3'(k)) begin
                    rsp_valid[k]      <= 1'b1;
                    rsp_y[32*k +: 32] <= sqrt_y;
                end else if (rsp_valid[k] && rsp_ready[k]) begin
                    rsp_valid[k] <= 1'b0;
                end
            end
`ifdef FSQRT_ARB_RR_EN
            if (grant_any)
                rr_ptr <= PW'((32'(winner) + 1) % NREQ);
`endif
        end
    end

endmodule
